imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 105 ++++++++++
 tb/tb_imem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory fetch responder: one-entry address stage feeding a two-entry response FIFO.
// Optional misaligned-fetch trap enabled by defining IMEM_MISALIGN_TRAP_EN.
module imem_responder #(
    parameter int unsigned ADDR_W      = 6,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    input  logic [31:0]       req_pc,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_instr,
    output logic              resp_err,
    input  logic              resp_ready,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0]       r_mem [DEPTH];

    logic              r_as_valid;
    logic [ADDR_W-1:0] r_as_idx;

    logic [31:0]       r_fifo_data [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_cnt;

    logic              w_fifo_nonempty;
    logic              w_pop;
    logic              w_as_move;
    logic              w_as_free;
    logic              w_req_fire;
    logic [31:0]       w_push_data;
    logic              w_unused_pc;

    // Outputs are forced to their idle values while RST is high so reset looks clean immediately.
    assign w_fifo_nonempty = (r_cnt != 2'd0);
    assign w_pop           = w_fifo_nonempty & resp_ready & ~RST;
    assign w_as_move       = r_as_valid & ((r_cnt != 2'd2) | w_pop);
    assign w_as_free       = ~r_as_valid | w_as_move;
    assign w_req_fire      = req_valid & w_as_free & ~RST;

    assign req_ready  = RST | w_as_free;
    assign resp_valid = w_fifo_nonempty & ~RST;
    assign resp_instr = resp_valid ? r_fifo_data[r_rd_ptr] : RESET_INSTR;

    assign w_unused_pc = ^{req_pc[31:ADDR_W+2], req_pc[1:0]};

`ifdef IMEM_MISALIGN_TRAP_EN
    logic       r_as_mis;
    logic [1:0] r_fifo_err;

    assign w_push_data = r_as_mis ? 32'h0000_0000 : r_mem[r_as_idx];
    assign resp_err    = resp_valid & r_fifo_err[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_req_fire) begin
            r_as_mis <= (req_pc[1:0] != 2'b00);
        end
        if (!RST && w_as_move) begin
            r_fifo_err[r_wr_ptr] <= r_as_mis;
        end
    end
`else
    assign w_push_data = r_mem[r_as_idx];
    assign resp_err    = 1'b0;
`endif

    // Storage is never cleared; writes land even during reset and are seen by later reads only.
    always_ff @(posedge CLK) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_as_valid <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            if (w_req_fire) begin
                r_as_valid <= 1'b1;
                r_as_idx   <= req_pc[ADDR_W+1:2];
            end else if (w_as_move) begin
                r_as_valid <= 1'b0;
            end
            if (w_as_move) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_as_move} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus random traffic against a
// transaction-level model (outstanding queue, one-edge minimum latency, cap of three in flight).
module tb_imem_responder;

    localparam int          AW = 6;
    localparam int          NW = 1 << AW;
    localparam logic [31:0] RI = 32'hDEAD_BEEF;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid;
    logic [31:0]   req_pc;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_instr;
    logic          resp_err;
    logic          resp_ready;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    always #5 CLK = ~CLK;

    imem_responder #(
        .ADDR_W      (AW),
        .RESET_INSTR (RI)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } ent_t;

    logic [31:0] m_mem [NW];
    ent_t        q[$];
    int          cyc;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t        e;
        logic [31:0] word;
        word   = pc >> 2;
        e.acc  = cyc;
        e.data = m_mem[word % NW];
        e.err  = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
        if (pc % 4 != 0) begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end
`endif
        return e;
    endfunction

    // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
    task automatic cycle(input logic rst, input logic rv, input logic [31:0] pc, input logic rr,
                         input logic le, input logic [AW-1:0] la, input logic [31:0] ld,
                         output logic accepted);
        logic ev;
        logic er;
        RST        = rst;
        req_valid  = rv;
        req_pc     = pc;
        resp_ready = rr;
        load_en    = le;
        load_addr  = la;
        load_data  = ld;
        @(negedge CLK);
        ev = !rst && q.size() > 0 && q[0].acc < cyc;
        er = rst || q.size() < 3 || (q.size() == 3 && ev && rr);
        chk("req_ready", {31'b0, req_ready}, {31'b0, er});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
        if (ev) begin
            chk("resp_instr", resp_instr, q[0].data);
            chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].err});
        end else begin
            chk("idle_instr", resp_instr, RI);
            chk("idle_err", {31'b0, resp_err}, 32'b0);
        end
        @(posedge CLK);
        cyc++;
        accepted = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (ev && rr) void'(q.pop_front());
            if (rv && er) begin
                q.push_back(mk(pc));
                accepted = 1'b1;
            end
        end
        if (le) m_mem[la] = ld;
        #1;
    endtask

    initial begin
        logic        a;
        logic        rv;
        logic        rr;
        logic        le;
        logic        rs;
        logic [31:0] pc;
        int          tries;

        total = 0;
        bad   = 0;
        cyc   = 0;

        // Fill storage while held in reset; writes must land regardless.
        for (int i = 0; i < NW; i++) begin
            cycle(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, AW'(i),
                  (i == 5) ? 32'h2002_0004 : $urandom, a);
        end

        // Single fetch of word 5 with minimum latency.
        cycle(1'b0, 1'b1, 32'h14, 1'b1, 1'b0, '0, 32'h0, a);
        chk("req33_acc", {31'b0, a}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);

        // Back-to-back streaming.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 32'(i * 4), 1'b1, 1'b0, '0, 32'h0, a);
            chk("stream_acc", {31'b0, a}, 32'd1);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);

        // Backpressure: only three fit; the fourth waits for the consumer.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, '0, 32'h0, a);
            chk("bp_acc", {31'b0, a}, (i < 3) ? 32'd1 : 32'd0);
        end
        tries = 0;
        a     = 1'b0;
        while (!a && tries < 8) begin
            cycle(1'b0, 1'b1, 32'h10C, 1'b1, 1'b0, '0, 32'h0, a);
            tries++;
        end
        chk("bp_fourth_acc", {31'b0, a}, 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);

        // Reset with three outstanding drops them all.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'(i * 8), 1'b0, 1'b0, '0, 32'h0, a);
        cycle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, '0, 32'h0, a);
        chk("rst_no_acc", {31'b0, a}, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);

        // Misaligned fetch that wraps to word 0.
        cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1, 1'b0, '0, 32'h0, a);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);

        // Write to word 3 on the edge its pending read happens: old word first, new word after.
        cycle(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, '0, 32'h0, a);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, AW'(3), 32'hA5A5_0303, a);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);
        cycle(1'b0, 1'b1, 32'hC, 1'b1, 1'b0, '0, 32'h0, a);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);

        // Random traffic; loads only when no read can be pending at that edge.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 39) == 0);
            pc = $urandom;
            le = 1'b0;
            if (q.size() == 0 && $urandom_range(0, 1) == 1) begin
                rv = 1'b0;
                le = 1'b1;
            end
            cycle(rs, rv, pc, rr, le, AW'($urandom), $urandom, a);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
